// File: rtl/dptr_defs.sv
`default_nettype none
// ============================================================================
// Package : dptr_defs
// Purpose : Shared definitions for the R-type datapath, its sequencer and
//           benches: opcode/funct encodings, instruction field slices and
//           the sequencer state encodings.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package dptr_defs;

  // Instruction encodings
  localparam logic [5:0]  OPCODE_RTYPE = 6'b000000;
  localparam logic [5:0]  FUNCT_ADD    = 6'b100000;
  localparam logic [5:0]  FUNCT_SUB    = 6'b100010;
  localparam logic [5:0]  FUNCT_AND    = 6'b100100;
  localparam logic [5:0]  FUNCT_OR     = 6'b100101;
  localparam logic [5:0]  FUNCT_SLT    = 6'b101010;
  localparam logic [31:0] INSTR_NOP    = 32'h0000_0000;

  // Sequencer state encodings
  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_FETCH  = 3'd1;
  localparam state_t ST_WAIT   = 3'd2;
  localparam state_t ST_SETTLE = 3'd3;
  localparam state_t ST_WRITE  = 3'd4;
  localparam state_t ST_NEXT   = 3'd5;
  localparam state_t ST_DONE   = 3'd6;

  // Instruction field slices
  function automatic logic [5:0] instr_opcode(input logic [31:0] instr);
    return instr[31:26];
  endfunction

  function automatic logic [4:0] instr_rs(input logic [31:0] instr);
    return instr[25:21];
  endfunction

  function automatic logic [4:0] instr_rt(input logic [31:0] instr);
    return instr[20:16];
  endfunction

  function automatic logic [4:0] instr_rd(input logic [31:0] instr);
    return instr[15:11];
  endfunction

  function automatic logic [5:0] instr_funct(input logic [31:0] instr);
    return instr[5:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/dptr_rdecode.sv
`default_nettype none
// ============================================================================
// Module  : dptr_rdecode
// Purpose : Combinational R-type legality decode, shared by the sequencer and
//           the datapath ALU control.
// Ports   : instr (in, 32)  instruction word
//           legal (out, 1)  R-type opcode with a supported funct
//           nop   (out, 1)  all-zero instruction word
// Revision: 1.0 - initial release
// ============================================================================
module dptr_rdecode
  import dptr_defs::*;
(
  input  logic [31:0] instr,
  output logic        legal,
  output logic        nop
);

  // The all-zero word has funct 000000, so it never decodes as legal.
  always_comb begin
    nop   = (instr == INSTR_NOP);
    legal = 1'b0;
    if (instr_opcode(instr) == OPCODE_RTYPE) begin
      case (instr_funct(instr))
        FUNCT_ADD, FUNCT_SUB, FUNCT_AND, FUNCT_OR, FUNCT_SLT: legal = 1'b1;
        default:                                              legal = 1'b0;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/dptr_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : dptr_sequencer
// Purpose : Multi-cycle controller between program memory and the R-type
//           datapath. Fetches base..last (wrapping), drives legal
//           instructions to the datapath, waits a settle window, pulses the
//           register write strobe and tallies executed / zero-flag results.
// Ports   : clk, rst_n             clock, async active-low reset
//           start, base_addr,      run request and pc range (sampled in IDLE)
//           last_addr
//           im_rd, im_addr,        sync-read instruction memory interface
//           im_rdata
//           dp_instr, dp_wr_en,    datapath instruction bus, write strobe,
//           dp_zf                  zero flag
//           busy, done             run status
//           exec_cnt, zf_cnt, err  per-run saturating counters, sticky error
// Revision: 1.0 - initial release
// ============================================================================
module dptr_sequencer
  import dptr_defs::*;
#(
  parameter int ADDR_W = 5,
  parameter int SETTLE = 2,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] last_addr,
  output logic              im_rd,
  output logic [ADDR_W-1:0] im_addr,
  input  logic [31:0]       im_rdata,
  output logic [31:0]       dp_instr,
  output logic              dp_wr_en,
  input  logic              dp_zf,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  exec_cnt,
  output logic [CNT_W-1:0]  zf_cnt,
  output logic              err
);

  localparam int                SCNT_W      = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [SCNT_W-1:0] SETTLE_LOAD = SCNT_W'(SETTLE - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX     = '1;

  state_t            r_state;
  state_t            w_state_next;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] r_last;
  logic [SCNT_W-1:0] r_settle;
  logic              w_legal;
  logic              w_nop;

  dptr_rdecode u_rdecode (
    .instr (im_rdata),
    .legal (w_legal),
    .nop   (w_nop)
  );

  assign im_addr = r_pc;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic. im_rdata is only meaningful in WAIT, one cycle after
  // the FETCH read strobe.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:   if (start) w_state_next = ST_FETCH;
      ST_FETCH:  w_state_next = ST_WAIT;
      ST_WAIT:   w_state_next = w_legal ? ST_SETTLE : ST_NEXT;
      ST_SETTLE: if (r_settle == '0) w_state_next = ST_WRITE;
      ST_WRITE:  w_state_next = ST_NEXT;
      ST_NEXT:   w_state_next = (r_pc == r_last) ? ST_DONE : ST_FETCH;
      ST_DONE:   w_state_next = ST_IDLE;
      default:   w_state_next = ST_IDLE;
    endcase
  end

  // Outputs decoded from state. busy covers DONE, so a start arriving in the
  // DONE cycle is seen with busy high and is not accepted.
  always_comb begin
    im_rd    = (r_state == ST_FETCH);
    dp_wr_en = (r_state == ST_WRITE);
    done     = (r_state == ST_DONE);
    busy     = (r_state != ST_IDLE);
  end

  // pc, settle counter, instruction bus and result counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc     <= '0;
      r_last   <= '0;
      r_settle <= '0;
      dp_instr <= '0;
      exec_cnt <= '0;
      zf_cnt   <= '0;
      err      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_pc     <= base_addr;
            r_last   <= last_addr;
            exec_cnt <= '0;
            zf_cnt   <= '0;
            err      <= 1'b0;
          end
        end
        ST_WAIT: begin
          // Skipped words leave dp_instr untouched so the datapath input
          // stays stable across NOPs and illegal encodings.
          if (w_legal) begin
            dp_instr <= im_rdata;
            r_settle <= SETTLE_LOAD;
          end else if (!w_nop) begin
            err <= 1'b1;
          end
        end
        ST_SETTLE: begin
          if (r_settle != '0) r_settle <= r_settle - 1'b1;
        end
        ST_WRITE: begin
          if (exec_cnt != CNT_MAX)        exec_cnt <= exec_cnt + 1'b1;
          if (dp_zf && zf_cnt != CNT_MAX) zf_cnt   <= zf_cnt + 1'b1;
        end
        ST_NEXT: begin
          // Natural ADDR_W-bit wrap lets last < base run across the top.
          if (r_pc != r_last) r_pc <= r_pc + ADDR_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dptr_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : tb_dptr_sequencer
// Purpose : Scoreboard bench for dptr_sequencer. Stimulus queues expected
//           fetch addresses, write events and end-of-run results; a monitor
//           pops and compares whenever the DUT presents them.
// Ports   : none
// Revision: 1.0 - initial release
// ============================================================================
module tb_dptr_sequencer;

  localparam int ADDR_W = 5;
  localparam int SETTLE = 2;
  localparam int CNT_W  = 8;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic [ADDR_W-1:0] last_addr = '0;
  logic              im_rd;
  logic [ADDR_W-1:0] im_addr;
  logic [31:0]       im_rdata = '0;
  logic [31:0]       dp_instr;
  logic              dp_wr_en;
  logic              dp_zf;
  logic              busy;
  logic              done;
  logic [CNT_W-1:0]  exec_cnt;
  logic [CNT_W-1:0]  zf_cnt;
  logic              err;

  dptr_sequencer #(.ADDR_W(ADDR_W), .SETTLE(SETTLE), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .base_addr (base_addr),
    .last_addr (last_addr),
    .im_rd     (im_rd),
    .im_addr   (im_addr),
    .im_rdata  (im_rdata),
    .dp_instr  (dp_instr),
    .dp_wr_en  (dp_wr_en),
    .dp_zf     (dp_zf),
    .busy      (busy),
    .done      (done),
    .exec_cnt  (exec_cnt),
    .zf_cnt    (zf_cnt),
    .err       (err)
  );

  always #5 clk = ~clk;

  // Sync-read program memory
  logic [31:0] mem [0:31];
  always @(posedge clk) if (im_rd) im_rdata <= mem[im_addr];

  // Datapath stand-in: only "sub rs,rt" with rs==rt yields zero.
  assign dp_zf = (dp_instr[5:0] == 6'b100010) && (dp_instr[25:21] == dp_instr[20:16]);

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [31:0] instr; int off; } wr_t;
  typedef struct { int exec; int zf; int err; int off; } dn_t;

  int  addr_q[$];
  wr_t wr_q[$];
  dn_t dn_q[$];

  int errors = 0;
  int checks = 0;
  int start_cyc = 0;
  int  ea;
  wr_t ew;
  dn_t ed;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name);
    checks++;
    errors++;
    $display("FAIL %s: event at cycle %0d with nothing expected", name, cyc);
  endtask

  // Monitor: offsets are measured from the cycle start was presented in IDLE.
  always @(negedge clk) begin
    if (rst_n) begin
      if (start && !busy) start_cyc = cyc;
      if (im_rd) begin
        if (addr_q.size() == 0) unexpected("fetch_unexpected");
        else begin
          ea = addr_q.pop_front();
          check("fetch_addr", longint'(im_addr), longint'(ea));
        end
      end
      if (dp_wr_en) begin
        if (wr_q.size() == 0) unexpected("write_unexpected");
        else begin
          ew = wr_q.pop_front();
          check("write_instr", longint'(dp_instr), longint'(ew.instr));
          check("write_offset", longint'(cyc - start_cyc), longint'(ew.off));
        end
      end
      if (done) begin
        if (dn_q.size() == 0) unexpected("done_unexpected");
        else begin
          ed = dn_q.pop_front();
          check("done_exec_cnt", longint'(exec_cnt), longint'(ed.exec));
          check("done_zf_cnt", longint'(zf_cnt), longint'(ed.zf));
          check("done_err", longint'(err), longint'(ed.err));
          check("done_offset", longint'(cyc - start_cyc), longint'(ed.off));
        end
      end
    end
  end

  function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] fn);
    return {6'b000000, rs, rt, rd, 5'd0, fn};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic kick(input logic [ADDR_W-1:0] b, input logic [ADDR_W-1:0] l);
    start     = 1'b1;
    base_addr = b;
    last_addr = l;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (!done && n < 60) begin
      tick();
      n++;
    end
    if (!done) unexpected(name);
    tick();
  endtask

  logic [31:0] old_instr;

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 32'h0;
    mem[0] = rtype(5'd15, 5'd2, 5'd3, 6'b100010);
    mem[1] = rtype(5'd20, 5'd6, 5'd12, 6'b100000);

    // Reset state
    repeat (3) tick();
    check("rst_busy", longint'(busy), 0);
    check("rst_done", longint'(done), 0);
    check("rst_im_rd", longint'(im_rd), 0);
    check("rst_wr_en", longint'(dp_wr_en), 0);
    check("rst_dp_instr", longint'(dp_instr), 0);
    check("rst_exec_cnt", longint'(exec_cnt), 0);
    check("rst_zf_cnt", longint'(zf_cnt), 0);
    check("rst_err", longint'(err), 0);
    check("rst_im_addr", longint'(im_addr), 0);
    rst_n = 1'b1;
    tick();

    // 1: two legal instructions
    addr_q.push_back(0); addr_q.push_back(1);
    wr_q.push_back('{mem[0], 5}); wr_q.push_back('{mem[1], 11});
    dn_q.push_back('{2, 0, 0, 13});
    kick(5'd0, 5'd1);
    wait_done("t1_done_timeout");

    // 2: sub of equal registers sets the zero flag
    mem[4] = rtype(5'd5, 5'd5, 5'd7, 6'b100010);
    addr_q.push_back(4);
    wr_q.push_back('{mem[4], 5});
    dn_q.push_back('{1, 1, 0, 7});
    kick(5'd4, 5'd4);
    wait_done("t2_done_timeout");

    // 3: NOP, illegal lw, legal add
    old_instr = mem[4];
    mem[2] = 32'h0;
    mem[3] = {6'b100011, 5'd1, 5'd2, 16'd8};
    mem[4] = rtype(5'd1, 5'd2, 5'd3, 6'b100000);
    addr_q.push_back(2); addr_q.push_back(3); addr_q.push_back(4);
    wr_q.push_back('{mem[4], 11});
    dn_q.push_back('{1, 0, 1, 13});
    kick(5'd2, 5'd4);
    repeat (5) tick();
    check("t3_dp_instr_held", longint'(dp_instr), longint'(old_instr));
    wait_done("t3_done_timeout");

    // 4: wrap from 31 to 0; err cleared by the new start
    mem[31] = rtype(5'd7, 5'd8, 5'd9, 6'b100100);
    addr_q.push_back(31); addr_q.push_back(0);
    wr_q.push_back('{mem[31], 5}); wr_q.push_back('{mem[0], 11});
    dn_q.push_back('{2, 0, 0, 13});
    kick(5'd31, 5'd0);
    wait_done("t4_done_timeout");

    // 5: start mid-run and on the DONE cycle is ignored
    addr_q.push_back(0); addr_q.push_back(1);
    wr_q.push_back('{mem[0], 5}); wr_q.push_back('{mem[1], 11});
    dn_q.push_back('{2, 0, 0, 13});
    kick(5'd0, 5'd1);
    repeat (3) tick();
    check("t5_busy_mid", longint'(busy), 1);
    start = 1'b1; base_addr = 5'd9; last_addr = 5'd9;
    tick();
    start = 1'b0;
    repeat (8) tick();
    check("t5_done_cycle", longint'(done), 1);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("t5_busy_after_done", longint'(busy), 0);
    tick();
    check("t5_still_idle", longint'(busy), 0);
    check("t5_no_fetch", longint'(im_rd), 0);

    // 6: reset during SETTLE, then a clean run
    addr_q.push_back(4);
    kick(5'd4, 5'd4);
    repeat (2) tick();
    check("t6_busy_settle", longint'(busy), 1);
    rst_n = 1'b0;
    #1;
    check("t6_rst_busy", longint'(busy), 0);
    check("t6_rst_dp_instr", longint'(dp_instr), 0);
    check("t6_rst_wr_en", longint'(dp_wr_en), 0);
    check("t6_rst_done", longint'(done), 0);
    check("t6_rst_exec_cnt", longint'(exec_cnt), 0);
    tick(); tick();
    rst_n = 1'b1;
    tick();
    addr_q.push_back(0);
    wr_q.push_back('{mem[0], 5});
    dn_q.push_back('{1, 0, 0, 7});
    kick(5'd0, 5'd0);
    wait_done("t6_done_timeout");

    repeat (3) tick();
    check("left_fetch_q", longint'(addr_q.size()), 0);
    check("left_write_q", longint'(wr_q.size()), 0);
    check("left_done_q", longint'(dn_q.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
